cp0_intc: RTL and testbench

Coprocessor-0 interrupt/exception controller that consumes the timer's irq and other hardware interrupt lines.
- Holds the SR, Cause, EPC and PrID registers.
- Raises int_req to the CPU pipeline and records EPC and the exception cause on entry.
- Clears EXL on eret.
- Sits between the peripheral irq outputs (timer on hw_int[0]) and the CPU's exception/flush logic.
- Software accesses it via mfc0/mtc0 through addr/we/din/dout.

---
 rtl/cp0_intc_if.sv | 26 ++
 rtl/cp0_intc.sv | 89 ++++++++
 tb/tb_cp0_intc.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cp0_intc_if.sv
// CP0 access and exception-signalling bundle between the CPU pipeline/peripherals and cp0_intc.
interface cp0_intc_if;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic [5:0]  hw_int;
    logic [29:0] pc;
    logic        bd_in;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        eret;
    logic        int_req;
    logic [29:0] epc_out;
    logic        exl_out;

    modport master (
        output addr, we, din, hw_int, pc, bd_in, exc_req, exc_code, eret,
        input  dout, int_req, epc_out, exl_out
    );

    modport slave (
        input  addr, we, din, hw_int, pc, bd_in, exc_req, exc_code, eret,
        output dout, int_req, epc_out, exl_out
    );
endinterface

// File: rtl/cp0_intc.sv
// CP0 interrupt/exception controller: SR, Cause, EPC, PrID plus entry/eret sequencing.
// Latency: state updates on the next clk edge; dout and int_req are combinational from state.
// Backpressure: none, every strobe and event is consumed in the cycle it is presented.
module cp0_intc #(
    parameter logic [31:0] PRID = 32'h4D495053
) (
    input  logic        clk,
    input  logic        rst,
    cp0_intc_if.slave   bus
);
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic [5:0]  ip;
    logic        bd;
    logic [4:0]  exc_code_q;
    logic [29:0] epc;

    logic        int_req;
    logic        entry;
    logic        sr_wr;
    logic        epc_wr;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req = (|(ip & im)) & ie & ~exl;
    // EXL blocks nesting: a second exception while in the handler is dropped.
    assign entry   = (int_req | bus.exc_req) & ~exl;
    assign sr_wr   = bus.we && (bus.addr == 5'd12);
    assign epc_wr  = bus.we && (bus.addr == 5'd14);

    always_ff @(posedge clk) begin
        if (rst) begin
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            ip         <= '0;
            bd         <= 1'b0;
            exc_code_q <= '0;
            epc        <= '0;
        end else begin
            ip <= bus.hw_int;
            if (sr_wr) begin
                im <= bus.din[15:10];
                ie <= bus.din[0];
            end
            // Entry and eret both override a same-cycle mtc0 for EXL.
            if (entry)
                exl <= 1'b1;
            else if (bus.eret && exl)
                exl <= 1'b0;
            else if (sr_wr)
                exl <= bus.din[1];
            if (entry) begin
                epc        <= bus.bd_in ? (bus.pc - 30'd1) : bus.pc;
                bd         <= bus.bd_in;
                exc_code_q <= int_req ? 5'd0 : bus.exc_code;
            end else if (epc_wr) begin
                epc <= bus.din[31:2];
            end
        end
    end

    always_comb begin
        sr_word           = '0;
        sr_word[15:10]    = im;
        sr_word[1]        = exl;
        sr_word[0]        = ie;
        cause_word        = '0;
        cause_word[31]    = bd;
        cause_word[15:10] = ip;
        cause_word[6:2]   = exc_code_q;
    end

    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            5'd12:   bus.dout = sr_word;
            5'd13:   bus.dout = cause_word;
            5'd14:   bus.dout = {epc, 2'b00};
            5'd15:   bus.dout = PRID;
            default: bus.dout = '0;
        endcase
    end

    assign bus.int_req = int_req;
    assign bus.epc_out = epc;
    assign bus.exl_out = exl;
endmodule

// File: tb/tb_cp0_intc.sv
// Scoreboard bench for cp0_intc: a word-level CP0 model predicts outputs, a negedge monitor compares.
module tb_cp0_intc;
    localparam logic [31:0] PRID_V = 32'h4D495053;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_intc_if bus ();
    cp0_intc #(.PRID(PRID_V)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        ir;
        logic        exl;
        logic [29:0] epc;
        logic [31:0] dout;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ncyc   = 0;

    // Reference state kept as architectural register words.
    logic [31:0] m_sr, m_cause;
    logic [29:0] m_epc;

    function automatic logic m_int_req();
        return (|(m_cause[15:10] & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return {m_epc, 2'b00};
            5'd15:   return PRID_V;
            default: return 32'd0;
        endcase
    endfunction

    // Applies the rules for one rising edge using the inputs held on the bus.
    task automatic m_step();
        logic [31:0] nsr, ncause;
        logic [29:0] nepc;
        logic        ir, take;
        if (rst) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
            return;
        end
        ir     = m_int_req();
        take   = (ir | bus.exc_req) & ~m_sr[1];
        nsr    = m_sr;
        ncause = m_cause;
        nepc   = m_epc;
        if (bus.we && bus.addr == 5'd12) nsr = bus.din & 32'h0000FC03;
        if (bus.we && bus.addr == 5'd14) nepc = bus.din[31:2];
        if (take) begin
            nsr[1]       = 1'b1;
            nepc         = bus.bd_in ? bus.pc - 30'd1 : bus.pc;
            ncause[31]   = bus.bd_in;
            ncause[6:2]  = ir ? 5'd0 : bus.exc_code;
        end else if (bus.eret && m_sr[1]) begin
            nsr[1] = 1'b0;
        end
        ncause[15:10] = bus.hw_int;
        m_sr = nsr; m_cause = ncause; m_epc = nepc;
    endtask

    task automatic tick();
        exp_t e;
        e.ir   = m_int_req();
        e.exl  = m_sr[1];
        e.epc  = m_epc;
        e.dout = m_read(bus.addr);
        e.cyc  = ncyc;
        q.push_back(e);
        @(posedge clk);
        m_step();
        ncyc++;
        #1;
    endtask

    task automatic drv(input logic r, input logic [4:0] a, input logic w, input logic [31:0] d,
                       input logic [5:0] hw, input logic [29:0] p, input logic bd,
                       input logic ex, input logic [4:0] code, input logic er);
        rst = r; bus.addr = a; bus.we = w; bus.din = d; bus.hw_int = hw; bus.pc = p;
        bus.bd_in = bd; bus.exc_req = ex; bus.exc_code = code; bus.eret = er;
        tick();
    endtask

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("int_req", e.cyc, {31'd0, bus.int_req}, {31'd0, e.ir});
            check("exl_out", e.cyc, {31'd0, bus.exl_out}, {31'd0, e.exl});
            check("epc_out", e.cyc, {2'd0, bus.epc_out}, {2'd0, e.epc});
            check("dout",    e.cyc, bus.dout, e.dout);
        end
    end

    initial begin
        logic [4:0]  a;
        logic        w, ex, er, bd, r;
        logic [5:0]  hw;
        logic [29:0] p;
        rst = 1'b1; bus.addr = 0; bus.we = 0; bus.din = 0; bus.hw_int = 0; bus.pc = 0;
        bus.bd_in = 0; bus.exc_req = 0; bus.exc_code = 0; bus.eret = 0;
        m_sr = 0; m_cause = 0; m_epc = 0;
        repeat (2) @(posedge clk);
        #1;
        // 1: reset state, enable IM0/IE, timer irq causes entry
        drv(1, 5'd12, 0, 0, 6'h00, 30'h0, 0, 0, 0, 0);
        drv(0, 5'd12, 0, 0, 6'h00, 30'h0, 0, 0, 0, 0);
        drv(0, 5'd12, 1, 32'h0000_0401, 6'h01, 30'h0C00, 0, 0, 0, 0);
        drv(0, 5'd13, 0, 0, 6'h01, 30'h0C00, 0, 0, 0, 0);
        drv(0, 5'd14, 0, 0, 6'h01, 30'h0C00, 0, 0, 0, 0);
        drv(0, 5'd13, 0, 0, 6'h00, 30'h0C00, 0, 0, 0, 0);
        // 2: eret, then exception in a delay slot, eret again
        drv(0, 5'd12, 0, 0, 6'h00, 30'h0C00, 0, 0, 0, 1);
        drv(0, 5'd12, 0, 0, 6'h00, 30'h0C05, 1, 1, 5'd10, 0);
        drv(0, 5'd14, 0, 0, 6'h00, 30'h0C05, 0, 0, 0, 0);
        drv(0, 5'd13, 0, 0, 6'h00, 30'h0C05, 0, 0, 0, 1);
        drv(0, 5'd14, 0, 0, 6'h00, 30'h0C05, 0, 0, 0, 1);
        // 3: IM masked, all lines high, then unmask IM0
        drv(0, 5'd12, 1, 32'h0000_0001, 6'h3F, 30'h0100, 0, 0, 0, 0);
        drv(0, 5'd13, 0, 0, 6'h3F, 30'h0100, 0, 0, 0, 0);
        drv(0, 5'd12, 1, 32'h0000_0401, 6'h3F, 30'h0100, 0, 0, 0, 0);
        drv(0, 5'd13, 0, 0, 6'h00, 30'h0100, 0, 0, 0, 0);
        drv(0, 5'd12, 1, 32'h0000_0000, 6'h00, 30'h0100, 0, 0, 0, 0);
        // 4: exception, ignored nested exception, simultaneous int+exc
        drv(0, 5'd13, 0, 0, 6'h00, 30'h0200, 0, 1, 5'd8, 0);
        drv(0, 5'd13, 0, 0, 6'h00, 30'h0300, 0, 1, 5'd4, 0);
        drv(0, 5'd14, 0, 0, 6'h00, 30'h0300, 0, 0, 0, 1);
        drv(0, 5'd12, 1, 32'h0000_0401, 6'h01, 30'h0300, 0, 0, 0, 0);
        drv(0, 5'd13, 0, 0, 6'h01, 30'h0400, 0, 1, 5'd12, 0);
        drv(0, 5'd13, 0, 0, 6'h01, 30'h0400, 0, 0, 0, 0);
        // 5: mtc0 SR during entry, write to Cause ignored, PrID read
        drv(0, 5'd12, 1, 32'h0000_0401, 6'h01, 30'h0500, 0, 0, 0, 1);
        drv(0, 5'd12, 1, 32'h0000_0000, 6'h01, 30'h0600, 0, 0, 0, 0);
        drv(0, 5'd13, 1, 32'hFFFF_FFFF, 6'h01, 30'h0600, 0, 0, 0, 0);
        drv(0, 5'd13, 0, 0, 6'h01, 30'h0600, 0, 0, 0, 0);
        drv(0, 5'd15, 1, 32'h1234_5678, 6'h01, 30'h0600, 0, 0, 0, 0);
        drv(0, 5'd14, 1, 32'hDEAD_BEEF, 6'h01, 30'h0600, 0, 0, 0, 0);
        // pc wrap in delay slot at pc=0
        drv(0, 5'd12, 1, 32'h0000_0000, 6'h00, 30'h0, 0, 0, 0, 0);
        drv(0, 5'd14, 0, 0, 6'h00, 30'h0, 1, 1, 5'd9, 0);
        drv(0, 5'd14, 0, 0, 6'h01, 30'h0, 0, 0, 0, 0);
        // 6: reset mid-handler with an asserted line
        drv(1, 5'd12, 1, 32'h0000_0401, 6'h01, 30'h0700, 0, 1, 5'd3, 0);
        drv(0, 5'd13, 0, 0, 6'h01, 30'h0700, 0, 0, 0, 0);
        drv(0, 5'd13, 0, 0, 6'h01, 30'h0700, 0, 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = 5'd12;
                2:       a = 5'd13;
                3:       a = 5'd14;
                4:       a = 5'd15;
                default: a = 5'($urandom);
            endcase
            w  = ($urandom_range(0, 3) == 0);
            hw = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
            p  = ($urandom_range(0, 7) == 0) ? 30'h0 : 30'($urandom);
            bd = 1'($urandom);
            ex = ($urandom_range(0, 7) == 0);
            er = ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 149) == 0);
            if (er && w && a == 5'd12 && !m_sr[1]) er = 1'b0;
            drv(r, a, w, $urandom, hw, p, bd, ex, 5'($urandom), er);
        end
        drv(0, 5'd0, 0, 0, 6'h00, 30'h0, 0, 0, 0, 0);
        for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
        #1;
        check("queue_drained", ncyc, q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
